// File: rtl/i2c_sniffer.sv
// Passive I2C bus monitor: filters SDA/SCL, decodes START/STOP and byte+ACK frames,
// and queues captured bytes in a first-word-fall-through FIFO with trigger/error pulses.
module i2c_sniffer #(
  parameter int unsigned FILT_LEN   = 4,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [6:0]  ADDR_MATCH = 7'h00,
  parameter logic [6:0]  ADDR_MASK  = 7'h7F
) (
  input  logic                            sysclk,
  input  logic                            rst_n,
  input  logic                            sda_raw,
  input  logic                            scl_raw,
  input  logic                            trig_en,
  input  logic                            rd_en,
  input  logic                            clr_ovf,
  output logic [9:0]                      rd_data,
  output logic                            rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic                            overflow,
  output logic                            start_pulse,
  output logic                            stop_pulse,
  output logic                            frame_err,
  output logic                            trig,
  output logic                            bus_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FILT_LEN + 1);

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, ACTIVE} state_t;

  // Index 0 is SDA, index 1 is SCL throughout the filter path.
  logic [1:0]    sync1, sync2, filt, prev;
  logic [CW-1:0] cnt [2];

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= '1;
      sync2  <= '1;
      filt   <= '1;
      prev   <= '1;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      sync1 <= {scl_raw, sda_raw};
      sync2 <= sync1;
      prev  <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(FILT_LEN - 1)) begin
          filt[i] <= sync2[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  logic sda_f, scl_f, sda_p, scl_p;
  logic start_evt, stop_evt, bit_evt;

  assign sda_f = filt[0];
  assign scl_f = filt[1];
  assign sda_p = prev[0];
  assign scl_p = prev[1];

  // Requiring SCL high in both samples makes a coincident SCL rise a bit sample only.
  assign start_evt = scl_p & scl_f &  sda_p & ~sda_f;
  assign stop_evt  = scl_p & scl_f & ~sda_p &  sda_f;
  assign bit_evt   = ~scl_p & scl_f;

  state_t     state;
  logic [3:0] bit_cnt;
  logic [7:0] shift_reg;
  logic       sof_flag;
  logic       push;
  logic [9:0] push_word;

  assign push      = (state == ACTIVE) && bit_evt && (bit_cnt == 4'd8);
  assign push_word = {sof_flag, shift_reg, sda_f};

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= WAIT_IDLE;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      sof_flag    <= 1'b0;
      start_pulse <= 1'b0;
      stop_pulse  <= 1'b0;
      frame_err   <= 1'b0;
      trig        <= 1'b0;
      bus_busy    <= 1'b0;
    end else begin
      start_pulse <= 1'b0;
      stop_pulse  <= 1'b0;
      frame_err   <= 1'b0;
      trig        <= 1'b0;
      case (state)
        WAIT_IDLE: if (sda_f && scl_f) state <= IDLE;
        IDLE: begin
          if (start_evt) begin
            state       <= ACTIVE;
            start_pulse <= 1'b1;
            bus_busy    <= 1'b1;
            bit_cnt     <= '0;
            sof_flag    <= 1'b1;
          end else if (stop_evt) begin
            stop_pulse <= 1'b1;
          end
        end
        ACTIVE: begin
          if (start_evt) begin
            start_pulse <= 1'b1;
            sof_flag    <= 1'b1;
            bit_cnt     <= '0;
            frame_err   <= (bit_cnt != 4'd0);
          end else if (stop_evt) begin
            state      <= IDLE;
            stop_pulse <= 1'b1;
            bus_busy   <= 1'b0;
            bit_cnt    <= '0;
            frame_err  <= (bit_cnt != 4'd0);
          end else if (bit_evt) begin
            if (bit_cnt == 4'd8) begin
              sof_flag <= 1'b0;
              bit_cnt  <= '0;
            end else begin
              shift_reg <= {shift_reg[6:0], sda_f};
              bit_cnt   <= bit_cnt + 4'd1;
              // On the 8th sample shift_reg[6:0] already holds the 7-bit address.
              if (bit_cnt == 4'd7 && sof_flag && trig_en &&
                  ((shift_reg[6:0] & ADDR_MASK) == (ADDR_MATCH & ADDR_MASK)))
                trig <= 1'b1;
            end
          end
        end
        default: state <= WAIT_IDLE;
      endcase
    end
  end

  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, pop, do_push;

  assign full    = (count == (AW + 1)'(FIFO_DEPTH));
  assign pop     = rd_en && rd_valid;
  assign do_push = push && (!full || pop);

  // NOTE: storage is deliberately not reset; rd_data is masked while the FIFO is empty.
  always_ff @(posedge sysclk) begin
    if (do_push) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
      if (push && full && !pop) overflow <= 1'b1;
      else if (clr_ovf)         overflow <= 1'b0;
    end
  end

  assign rd_valid   = (count != '0);
  assign rd_data    = rd_valid ? mem[rd_ptr] : '0;
  assign fifo_count = count;

endmodule

// File: tb/tb_i2c_sniffer.sv
// Directed bench for i2c_sniffer: bit-banged I2C frames on the raw pins, with
// pulse counters sampled on the falling clock edge and hand-computed expectations.
module tb_i2c_sniffer;

  localparam int H = 10;  // sysclk cycles per SCL phase, above the FILT_LEN+2 minimum

  logic       sysclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sda_raw = 1'b1;
  logic       scl_raw = 1'b1;
  logic       trig_en = 1'b0;
  logic       rd_en = 1'b0;
  logic       clr_ovf = 1'b0;
  logic [9:0] rd_data;
  logic       rd_valid;
  logic [2:0] fifo_count;
  logic       overflow, start_pulse, stop_pulse, frame_err, trig, bus_busy;

  int pass_cnt = 0;
  int total_cnt = 0;
  int n_start = 0, n_stop = 0, n_ferr = 0, n_trig = 0;
  int cur_bit = -1;
  int trig_bit = -1;

  i2c_sniffer #(
    .FILT_LEN(4), .FIFO_DEPTH(4), .ADDR_MATCH(7'h50), .ADDR_MASK(7'h7F)
  ) dut (
    .sysclk(sysclk), .rst_n(rst_n), .sda_raw(sda_raw), .scl_raw(scl_raw),
    .trig_en(trig_en), .rd_en(rd_en), .clr_ovf(clr_ovf), .rd_data(rd_data),
    .rd_valid(rd_valid), .fifo_count(fifo_count), .overflow(overflow),
    .start_pulse(start_pulse), .stop_pulse(stop_pulse), .frame_err(frame_err),
    .trig(trig), .bus_busy(bus_busy)
  );

  always #5 sysclk = ~sysclk;

  // Counts every cycle a pulse is high, so a stretched pulse shows as an extra count.
  always @(negedge sysclk) begin
    if (start_pulse) n_start <= n_start + 1;
    if (stop_pulse)  n_stop  <= n_stop + 1;
    if (frame_err)   n_ferr  <= n_ferr + 1;
    if (trig) begin
      n_trig   <= n_trig + 1;
      trig_bit <= cur_bit;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic i2c_start();
    sda_raw = 1'b1; wait_cyc(H);
    scl_raw = 1'b1; wait_cyc(H);
    sda_raw = 1'b0; wait_cyc(H);
    scl_raw = 1'b0; wait_cyc(H);
  endtask

  task automatic i2c_stop();
    sda_raw = 1'b0; wait_cyc(H);
    scl_raw = 1'b1; wait_cyc(H);
    sda_raw = 1'b1; wait_cyc(H);
  endtask

  task automatic send_bit(input logic b);
    sda_raw = b;    wait_cyc(H);
    scl_raw = 1'b1; wait_cyc(H);
    scl_raw = 1'b0; wait_cyc(H);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic ack);
    for (int i = 7; i >= 0; i--) begin
      cur_bit = 7 - i;
      send_bit(b[i]);
    end
    cur_bit = 8;
    send_bit(ack);
    cur_bit = -1;
  endtask

  task automatic pop();
    rd_en = 1'b1; wait_cyc(1);
    rd_en = 1'b0; wait_cyc(1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wait_cyc(3);
    total_cnt++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid: got %b want 0", rd_valid); else pass_cnt++;
    total_cnt++; if (fifo_count !== 3'd0) $display("FAIL reset_count: got %0d want 0", fifo_count); else pass_cnt++;
    total_cnt++; if (rd_data !== 10'h000) $display("FAIL reset_rd_data: got %h want 000", rd_data); else pass_cnt++;
    total_cnt++; if ({overflow, bus_busy} !== 2'b00) $display("FAIL reset_ovf_busy: got %b want 00", {overflow, bus_busy}); else pass_cnt++;
    total_cnt++; if ({start_pulse, stop_pulse, frame_err, trig} !== 4'b0000)
      $display("FAIL reset_pulses: got %b want 0000", {start_pulse, stop_pulse, frame_err, trig}); else pass_cnt++;
    rst_n = 1'b1;
    wait_cyc(20);
  endtask

  task automatic test_write();
    int s0, p0;
    s0 = n_start; p0 = n_stop;
    i2c_start();
    send_byte(8'hA0, 1'b0);
    total_cnt++; if (bus_busy !== 1'b1) $display("FAIL write_busy_mid: got %b want 1", bus_busy); else pass_cnt++;
    send_byte(8'h5A, 1'b1);
    i2c_stop();
    wait_cyc(20);
    total_cnt++; if (fifo_count !== 3'd2) $display("FAIL write_count: got %0d want 2", fifo_count); else pass_cnt++;
    total_cnt++; if (rd_data !== {1'b1, 8'hA0, 1'b0}) $display("FAIL write_entry0: got %h want 340", rd_data); else pass_cnt++;
    pop();
    total_cnt++; if (rd_data !== {1'b0, 8'h5A, 1'b1}) $display("FAIL write_entry1: got %h want 0b5", rd_data); else pass_cnt++;
    pop();
    total_cnt++; if (rd_valid !== 1'b0) $display("FAIL write_drained: got %b want 0", rd_valid); else pass_cnt++;
    total_cnt++; if (n_start - s0 !== 1) $display("FAIL write_start_pulses: got %0d want 1", n_start - s0); else pass_cnt++;
    total_cnt++; if (n_stop - p0 !== 1) $display("FAIL write_stop_pulses: got %0d want 1", n_stop - p0); else pass_cnt++;
    total_cnt++; if (bus_busy !== 1'b0) $display("FAIL write_busy_end: got %b want 0", bus_busy); else pass_cnt++;
  endtask

  task automatic test_trig();
    int t0;
    trig_en = 1'b1;
    t0 = n_trig;
    i2c_start(); send_byte(8'hA1, 1'b0); i2c_stop(); wait_cyc(20);
    total_cnt++; if (n_trig - t0 !== 1) $display("FAIL trig_match: got %0d want 1", n_trig - t0); else pass_cnt++;
    total_cnt++; if (trig_bit !== 7) $display("FAIL trig_before_ack: fired in bit %0d want 7", trig_bit); else pass_cnt++;
    t0 = n_trig;
    i2c_start(); send_byte(8'hA2, 1'b0); i2c_stop(); wait_cyc(20);
    total_cnt++; if (n_trig - t0 !== 0) $display("FAIL trig_nomatch: got %0d want 0", n_trig - t0); else pass_cnt++;
    trig_en = 1'b0;
    t0 = n_trig;
    i2c_start(); send_byte(8'hA1, 1'b0); i2c_stop(); wait_cyc(20);
    total_cnt++; if (n_trig - t0 !== 0) $display("FAIL trig_disabled: got %0d want 0", n_trig - t0); else pass_cnt++;
    total_cnt++; if (rd_data !== {1'b1, 8'hA1, 1'b0}) $display("FAIL trig_entry0: got %h want 342", rd_data); else pass_cnt++;
    pop(); pop(); pop();
    total_cnt++; if (fifo_count !== 3'd0) $display("FAIL trig_drained: got %0d want 0", fifo_count); else pass_cnt++;
  endtask

  task automatic test_repeated_start();
    int s0, p0;
    s0 = n_start; p0 = n_stop;
    i2c_start();
    send_byte(8'hA0, 1'b0);
    i2c_start();
    total_cnt++; if (n_start - s0 !== 2) $display("FAIL sr_start_pulses: got %0d want 2", n_start - s0); else pass_cnt++;
    total_cnt++; if (n_stop - p0 !== 0) $display("FAIL sr_no_stop: got %0d want 0", n_stop - p0); else pass_cnt++;
    send_byte(8'hA1, 1'b0);
    i2c_stop();
    wait_cyc(20);
    total_cnt++; if (fifo_count !== 3'd2) $display("FAIL sr_count: got %0d want 2", fifo_count); else pass_cnt++;
    total_cnt++; if (rd_data !== {1'b1, 8'hA0, 1'b0}) $display("FAIL sr_entry0: got %h want 340", rd_data); else pass_cnt++;
    pop();
    total_cnt++; if (rd_data !== {1'b1, 8'hA1, 1'b0}) $display("FAIL sr_entry1: got %h want 342", rd_data); else pass_cnt++;
    pop();
  endtask

  task automatic test_frame_err();
    int f0;
    f0 = n_ferr;
    i2c_start();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    i2c_stop();
    wait_cyc(20);
    total_cnt++; if (n_ferr - f0 !== 1) $display("FAIL ferr_pulse: got %0d cycles want 1", n_ferr - f0); else pass_cnt++;
    total_cnt++; if (fifo_count !== 3'd0) $display("FAIL ferr_no_push: got %0d want 0", fifo_count); else pass_cnt++;
    total_cnt++; if (bus_busy !== 1'b0) $display("FAIL ferr_idle: got %b want 0", bus_busy); else pass_cnt++;
  endtask

  task automatic test_overflow();
    logic [9:0] exp_q [4];
    exp_q[0] = {1'b0, 8'h12, 1'b0};
    exp_q[1] = {1'b0, 8'h13, 1'b0};
    exp_q[2] = {1'b0, 8'h14, 1'b0};
    exp_q[3] = {1'b1, 8'h16, 1'b0};
    i2c_start();
    for (int k = 0; k < 5; k++) send_byte(8'h11 + 8'(k), 1'b0);
    i2c_stop();
    wait_cyc(20);
    total_cnt++; if (fifo_count !== 3'd4) $display("FAIL ovf_count: got %0d want 4", fifo_count); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b1) $display("FAIL ovf_set: got %b want 1", overflow); else pass_cnt++;
    total_cnt++; if (rd_data !== {1'b1, 8'h11, 1'b0}) $display("FAIL ovf_head: got %h want 222", rd_data); else pass_cnt++;
    clr_ovf = 1'b1; wait_cyc(1);
    clr_ovf = 1'b0; wait_cyc(1);
    total_cnt++; if (overflow !== 1'b0) $display("FAIL ovf_clear: got %b want 0", overflow); else pass_cnt++;
    // Pop timed to the push edge: raw SCL rise + 2 sync + 4 filter cycles, pushed on the next edge.
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(1'(8'h16 >> i));
    sda_raw = 1'b0; wait_cyc(H);
    scl_raw = 1'b1; wait_cyc(6);
    rd_en = 1'b1;   wait_cyc(1);
    rd_en = 1'b0;   wait_cyc(H - 7);
    scl_raw = 1'b0; wait_cyc(H);
    i2c_stop();
    wait_cyc(20);
    total_cnt++; if (fifo_count !== 3'd4) $display("FAIL ovf_push_pop_count: got %0d want 4", fifo_count); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b0) $display("FAIL ovf_push_pop_flag: got %b want 0", overflow); else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      total_cnt++; if (rd_data !== exp_q[k]) $display("FAIL ovf_drain%0d: got %h want %h", k, rd_data, exp_q[k]); else pass_cnt++;
      pop();
    end
    total_cnt++; if (rd_valid !== 1'b0) $display("FAIL ovf_drained: got %b want 0", rd_valid); else pass_cnt++;
  endtask

  task automatic test_glitch();
    int s0;
    s0 = n_start;
    sda_raw = 1'b0; wait_cyc(2);
    sda_raw = 1'b1; wait_cyc(20);
    total_cnt++; if (n_start - s0 !== 0) $display("FAIL glitch_start: got %0d want 0", n_start - s0); else pass_cnt++;
    total_cnt++; if (bus_busy !== 1'b0) $display("FAIL glitch_busy: got %b want 0", bus_busy); else pass_cnt++;
  endtask

  task automatic test_reset_mid_byte();
    int s1;
    i2c_start();
    send_byte(8'h3C, 1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    total_cnt++; if (fifo_count !== 3'd1) $display("FAIL mid_pre_count: got %0d want 1", fifo_count); else pass_cnt++;
    rst_n = 1'b0;
    wait_cyc(2);
    total_cnt++; if ({rd_valid, fifo_count, rd_data} !== 14'd0)
      $display("FAIL mid_reset_fifo: got valid=%b count=%0d data=%h want all 0", rd_valid, fifo_count, rd_data); else pass_cnt++;
    total_cnt++; if ({overflow, bus_busy, start_pulse, stop_pulse, frame_err, trig} !== 6'd0)
      $display("FAIL mid_reset_flags: got %b want 000000", {overflow, bus_busy, start_pulse, stop_pulse, frame_err, trig}); else pass_cnt++;
    rst_n = 1'b1;
    s1 = n_start;
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    send_byte(8'h55, 1'b0);
    i2c_stop();
    wait_cyc(20);
    total_cnt++; if (fifo_count !== 3'd0) $display("FAIL mid_ignored: got %0d want 0", fifo_count); else pass_cnt++;
    total_cnt++; if (n_start - s1 !== 0) $display("FAIL mid_no_start: got %0d want 0", n_start - s1); else pass_cnt++;
    i2c_start(); send_byte(8'h77, 1'b1); i2c_stop(); wait_cyc(20);
    total_cnt++; if (rd_data !== {1'b1, 8'h77, 1'b1}) $display("FAIL mid_recover: got %h want 2ef", rd_data); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_trig();
    test_repeated_start();
    test_frame_err();
    test_overflow();
    test_glitch();
    test_reset_mid_byte();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/i2c_sniffer.md
# i2c_sniffer

Passive, parametrised I2C bus monitor: filters raw SDA/SCL, detects START/repeated-START/STOP, deserialises each 8-bit byte plus ACK bit, and buffers completed bytes in a first-word-fall-through FIFO with a valid/pop handshake. It adds an address-match trigger pulse for glitch-timing logic, framing-error detection and overflow reporting. It never drives the bus. It sits between the bus pins and the capture/trigger logic.

## Interface
- FILT_LEN, 4: consecutive stable sysclk samples required before a filtered line changes (≥1).
- FIFO_DEPTH, 16: entries in byte FIFO; power of two, ≥2.
- ADDR_MATCH, 7'h00: 7-bit address compared against the first byte after START.
- ADDR_MASK, 7'h7F: compare mask; 0 bits are don't-care.
- sysclk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sda_raw  in  1  unsynchronised bus SDA.
- scl_raw  in  1  unsynchronised bus SCL.
- trig_en  in  1  arms address-match trigger.
- rd_en  in  1  pop FIFO head; ignored when rd_valid=0.
- clr_ovf  in  1  clears sticky overflow.
- rd_data  out  10  FIFO head {sof, data[7:0], ack_n}; sof=1 marks first byte after START/Sr; ack_n is the 9th sampled bit.
- rd_valid  out  1  FIFO not empty.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy.
- overflow  out  1  sticky: byte dropped because FIFO full.
- start_pulse  out  1  one-cycle pulse on START or repeated START.
- stop_pulse  out  1  one-cycle pulse on STOP.
- frame_err  out  1  one-cycle pulse: START/STOP with 1–8 bits of a byte collected.
- trig  out  1  one-cycle address-match pulse.
- bus_busy  out  1  high from START to STOP.

## Operation
- Filter per line: 2-FF synchroniser, then counter; filtered output takes the synchronised value after it has differed from the current output for FILT_LEN consecutive cycles. Counter clears on any agreeing sample. Filtered outputs reset to 1.
- Events on filtered signals (prev registered): START = SDA 1→0 with SCL=1 in both samples; STOP = SDA 0→1 with SCL=1 in both samples; bit sample = SCL 0→1. Same-cycle SCL rise and SDA change counts as a bit sample, not START/STOP.
- States: WAIT_IDLE (reset state), IDLE, ACTIVE.
  - WAIT_IDLE → IDLE when filtered SDA=SCL=1. Events ignored here.
  - IDLE → ACTIVE on START: start_pulse, bus_busy=1, bit_cnt=0, sof_flag=1.
  - ACTIVE: each bit sample shifts SDA in MSB-first, bit_cnt++. On 9th sample: push {sof_flag, byte, sampled bit}, clear sof_flag, bit_cnt=0.
  - ACTIVE + START (Sr): start_pulse, sof_flag=1, bit_cnt=0; frame_err if bit_cnt was 1–8. Partial byte discarded.
  - ACTIVE + STOP → IDLE: stop_pulse, bus_busy=0; frame_err if bit_cnt 1–8; partial discarded.
  - STOP in IDLE: stop_pulse only.
- Trigger: on 8th bit sample with sof_flag=1 and trig_en=1, if (byte[7:1] & ADDR_MASK) == (ADDR_MATCH & ADDR_MASK), trig pulses. R/W bit ignored. Fires before ACK.
- FIFO: push when 9th bit sampled; pop when rd_en && rd_valid. Full + push without pop: byte dropped, overflow set. Full + push + pop same cycle: both accepted, count unchanged. Empty + push: rd_valid next cycle. Pointers wrap modulo FIFO_DEPTH. clr_ovf and simultaneous new overflow: overflow stays 1.

## Timing
- Reset (asynchronous assert, any time including mid-byte): state=WAIT_IDLE; FIFO empty; rd_valid=0, fifo_count=0, rd_data=0, overflow=0; all pulses, trig and bus_busy 0; filters=1; shift register and bit_cnt=0.
- Pin-to-filtered latency: 2 + FILT_LEN cycles.
- Event outputs (start_pulse, stop_pulse, frame_err, trig) are registered: high exactly 1 cycle, in the cycle after the filtered edge is first seen.
- FIFO push visible: rd_valid/fifo_count update 1 cycle after the 9th sample edge is seen. rd_data is valid combinationally from the head entry while rd_valid=1. After a pop, the next entry is presented in the next cycle.
- Minimum SCL high/low time for correct capture: FILT_LEN+2 sysclk.

## Test plan
- Write 0xA0+ACK, 0x5A+NACK, STOP, FILT_LEN=4 -> entries {1,A0,0}, {0,5A,1}; one start_pulse, one stop_pulse, bus_busy returns to 0.
- ADDR_MATCH=7'h50, mask 7F, trig_en=1, address byte 0xA1 -> trig pulses once, before the ACK sample. Address 0xA2 -> no trig. trig_en=0 -> no trig.
- Repeated START after 0xA0+ACK, then 0xA1+ACK -> two sof=1 entries, two start_pulse, no stop_pulse in between.
- STOP after 3 bits -> frame_err=1 for 1 cycle, no push, state IDLE.
- FIFO_DEPTH=4, 5 bytes, no pops -> fifo_count=4, overflow=1, 5th byte lost. Then pop on the same cycle as a push while full -> count stays 4. clr_ovf -> overflow=0.
- 2-cycle SDA glitch with SCL high (FILT_LEN=4) -> no START; rst_n low mid-byte -> all outputs 0, and bytes are ignored until the bus is idle.
